// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between an issuing stage and muldiv_unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic start, kill, busy, valid;
  logic [2:0] op;
  logic [XLEN-1:0] data1, data2, result;
  modport master(output start, op, data1, data2, kill, input busy, valid, result);
  modport slave(input start, op, data1, data2, kill, output busy, valid, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency multiplier and restoring radix-2 divider for RV32M/RV64M ops.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN + MUL_LATENCY + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_r;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] q, r, d, q_n, r_n, res_n;
  logic [XLEN:0] rs, diff;
  logic neg_q, neg_r, accept, sgn, ovf, early, last;
  function automatic logic [XLEN-1:0] mul_f(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN+1:0] ae, be, p;
    ae = {{(XLEN+2){a[XLEN-1] & (o[1:0] == 2'b01 || o[1:0] == 2'b10)}}, a};
    be = {{(XLEN+2){b[XLEN-1] & (o[1:0] == 2'b01)}}, b};
    p = ae * be;
    return o[1:0] == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction
  function automatic logic [XLEN-1:0] abs_f(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction
  // Divide-by-zero and signed overflow finish at the accepting edge.
  always_comb begin
    accept = (state == IDLE || state == DONE) && bus.start && !bus.kill;
    sgn = ~bus.op[0];
    ovf = sgn && bus.data1 == MIN && bus.data2 == '1;
    early = bus.op[2] && (bus.data2 == '0 || ovf);
    last = state == DIV ? cnt == CW'(XLEN - 1) : cnt == CW'(MUL_LATENCY - 2);
    rs = {r, q[XLEN-1]};
    diff = rs - {1'b0, d};
    q_n = {q[XLEN-2:0], ~diff[XLEN]};
    r_n = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
    res_n = accept ? (early ? (bus.data2 == '0 ? (bus.op[1] ? bus.data1 : '1) : (bus.op[1] ? '0 : bus.data1))
                            : mul_f(bus.op, bus.data1, bus.data2))
          : state == MUL ? mul_f(op_r, q, d)
          : op_r[1] ? (neg_r ? -r_n : r_n) : (neg_q ? -q_n : q_n);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (bus.kill) state_n = IDLE;
    else if (state == IDLE || state == DONE)
      state_n = !accept ? IDLE : (early || (!bus.op[2] && MUL_LATENCY == 1)) ? DONE : bus.op[2] ? DIV : MUL;
    else if (last) state_n = DONE;
  end
  always_comb begin
    bus.busy = state == MUL || state == DIV;
    bus.valid = state == DONE;
  end
  // Multiplies keep raw operands in q/d; divides keep magnitudes and the sign fix-ups.
  always_ff @(posedge clk)
    if (reset) begin
      {op_r, cnt, q, r, d, neg_q, neg_r} <= '0;
      bus.result <= '0;
    end else begin
      if (accept) begin
        op_r <= bus.op;
        cnt <= '0;
        r <= '0;
        q <= bus.op[2] ? abs_f(bus.data1, sgn) : bus.data1;
        d <= bus.op[2] ? abs_f(bus.data2, sgn) : bus.data2;
        neg_q <= sgn & (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]);
        neg_r <= sgn & bus.data1[XLEN-1];
      end else if (state == DIV) begin
        q <= q_n;
        r <= r_n;
        cnt <= cnt + CW'(1);
      end else if (state == MUL) cnt <= cnt + CW'(1);
      if (state_n == DONE) bus.result <= res_n;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of latency, results, early-outs, back-to-back, kill and reset.
module tb_muldiv_unit;
  logic clk = 0, reset;
  int total = 0, passed = 0;
  logic seen;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut(.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp);
    bus.start = 1; bus.op = op; bus.data1 = a; bus.data2 = b;
    tick;
    bus.start = 0; bus.op = ~op; bus.data1 = $urandom; bus.data2 = $urandom;
    for (int c = 1; c < lat; c++) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      chk({tag, " early valid"}, 32'(bus.valid), 32'd0);
      tick;
    end
    chk({tag, " valid"}, 32'(bus.valid), 32'd1);
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    chk({tag, " result"}, bus.result, exp);
  endtask
  task automatic watch_no_valid(input string tag);
    seen = 0;
    repeat (40) begin
      if (bus.valid) seen = 1;
      tick;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask
  initial begin
    reset = 1; bus.start = 0; bus.kill = 0; bus.op = 0; bus.data1 = 0; bus.data2 = 0;
    tick; tick;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset valid", 32'(bus.valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    reset = 0;
    tick;
    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFEB);
    tick;
    chk("mul valid drop", 32'(bus.valid), 32'd0);
    chk("mul result hold", bus.result, 32'hFFFFFFEB);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
    run_op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'h00000000);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
    run_op("mulh min", 3'b001, 32'h80000000, 32'h80000000, 2, 32'h40000000);
    run_op("mulhsu neg", 3'b010, 32'hFFFFFFFE, 32'd3, 2, 32'hFFFFFFFF);
    run_op("mulhu big", 3'b011, 32'h80000000, 32'd4, 2, 32'h00000002);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
    run_op("div negneg", 3'b100, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 32'd3);
    run_op("rem negneg", 3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 32'hFFFFFFFF);
    run_op("divu", 3'b101, 32'hFFFFFFFF, 32'd10, 33, 32'h19999999);
    run_op("remu", 3'b111, 32'hFFFFFFFF, 32'd10, 33, 32'd5);
    run_op("divu by0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
    run_op("remu by0", 3'b111, 32'd5, 32'd0, 1, 32'd5);
    run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);
    tick;
    bus.start = 1; bus.op = 3'b100; bus.data1 = 32'd20; bus.data2 = 32'd3;
    tick;
    for (int c = 1; c <= 32; c++) begin
      chk("b2b div busy", 32'(bus.busy), 32'd1);
      chk("b2b div valid", 32'(bus.valid), 32'd0);
      bus.start = (c == 5 || c == 32); bus.op = 3'b000; bus.data1 = 32'd6; bus.data2 = 32'd7;
      tick;
    end
    chk("b2b div done valid", 32'(bus.valid), 32'd1);
    chk("b2b div result", bus.result, 32'd6);
    tick;
    bus.start = 0;
    chk("b2b mul busy", 32'(bus.busy), 32'd1);
    chk("b2b mul not valid", 32'(bus.valid), 32'd0);
    tick;
    chk("b2b mul valid", 32'(bus.valid), 32'd1);
    chk("b2b mul result", bus.result, 32'd42);
    tick;
    bus.start = 1; bus.op = 3'b100; bus.data1 = 32'd100; bus.data2 = 32'd7;
    tick;
    bus.start = 0;
    repeat (9) tick;
    bus.kill = 1;
    tick;
    bus.kill = 0;
    chk("kill busy", 32'(bus.busy), 32'd0);
    chk("kill valid", 32'(bus.valid), 32'd0);
    chk("kill result", bus.result, 32'd42);
    watch_no_valid("kill no valid");
    bus.start = 1; bus.kill = 1; bus.op = 3'b000; bus.data1 = 32'd3; bus.data2 = 32'd3;
    tick;
    bus.start = 0; bus.kill = 0;
    chk("kill over start busy", 32'(bus.busy), 32'd0);
    tick;
    chk("kill over start valid", 32'(bus.valid), 32'd0);
    bus.start = 1; bus.op = 3'b100; bus.data1 = 32'd100; bus.data2 = 32'd7;
    tick;
    bus.start = 0;
    repeat (4) tick;
    reset = 1;
    tick;
    chk("rst mid busy", 32'(bus.busy), 32'd0);
    chk("rst mid valid", 32'(bus.valid), 32'd0);
    chk("rst mid result", bus.result, 32'd0);
    reset = 0;
    watch_no_valid("rst no valid");
    run_op("mul after rst", 3'b000, 32'd3, 32'd5, 2, 32'd15);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
